kamacore_dmem_responder: RTL and testbench

KAMACORE_DMEM_RESPONDER -- requirements
Module: kamacore_dmem_responder

---
 rtl/kamacore_pkg.sv | 14 +
 rtl/kamacore_dmem_array.sv | 39 +++
 rtl/kamacore_dmem_responder.sv | 116 +++++++++++
 tb/tb_kamacore_dmem_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/kamacore_pkg.sv
// Shared kamacore datatypes: datapath width and the
// data-memory responder FSM state encoding.
package kamacore_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int BE_W      = CPU_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/kamacore_dmem_array.sv
// Word-organised data storage: one byte-enabled write port and
// one synchronous read port sharing a single word address.
// Ports: clk, we/be/wdata (write), re (read), addr, rdata (registered).
module kamacore_dmem_array
  import kamacore_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        addr,
  input  logic [CPU_WIDTH-1:0] wdata,
  input  logic [BE_W-1:0]      be,
  output logic [CPU_WIDTH-1:0] rdata
);

  logic [CPU_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [CPU_WIDTH-1:0] rdata_q;

  // Contents are never reset; the read register only moves on re,
  // so it holds a captured load until the next one.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/kamacore_dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// Ports: clk, rst, req_* (request handshake), rsp_* (response handshake).
module kamacore_dmem_responder
  import kamacore_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [CPU_WIDTH-1:0] req_addr,
  input  logic [CPU_WIDTH-1:0] req_wdata,
  input  logic [BE_W-1:0]      req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CPU_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_INIT_I = (LATENCY >= 2) ? (LATENCY - 2) : 0;
  localparam logic [1:0] CNT_INIT = CNT_INIT_I[1:0];

  dmem_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        ld_q, ld_d;

  logic                 accept;
  logic                 addr_err;
  logic                 arr_we;
  logic                 arr_re;
  logic [CPU_WIDTH-1:0] arr_rdata;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  assign addr_err = (req_addr[1:0] != 2'b00) ||
                    (req_addr[CPU_WIDTH-1:2] >=
                     (CPU_WIDTH-2)'(DEPTH_WORDS));

  // Storage is touched only at the accept edge and never for errors.
  assign arr_we = accept && req_we && !addr_err;
  assign arr_re = accept && !req_we && !addr_err;

  kamacore_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (req_addr[AW+1:2]),
    .wdata (req_wdata),
    .be    (req_be),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ld_d    = ld_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = addr_err;
          ld_d  = !req_we;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
    end
  end

  // Outputs are decoded from flops only; data is zero outside RESP
  // and for stores or errors.
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && ld_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_kamacore_dmem_responder.sv
// Directed bench for kamacore_dmem_responder: LATENCY=2 main
// instance plus LATENCY=1 and LATENCY=4 instances.
module tb_kamacore_dmem_responder;
  import kamacore_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2:0]           req_valid_v = '0;
  logic [2:0]           req_ready_v;
  logic                 req_we = 1'b0;
  logic [CPU_WIDTH-1:0] req_addr = '0;
  logic [CPU_WIDTH-1:0] req_wdata = '0;
  logic [BE_W-1:0]      req_be = '0;
  logic [2:0]           rsp_valid_v;
  logic [2:0]           rsp_ready_v = '0;
  logic [CPU_WIDTH-1:0] rdata_a [3];
  logic [2:0]           rsp_err_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kamacore_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]),
    .rsp_rdata(rdata_a[0]), .rsp_err(rsp_err_v[0])
  );

  kamacore_dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]),
    .rsp_rdata(rdata_a[1]), .rsp_err(rsp_err_v[1])
  );

  kamacore_dmem_responder #(.DEPTH_WORDS(16), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready_v[2]),
    .rsp_rdata(rdata_a[2]), .rsp_err(rsp_err_v[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance d; stall = cycles held in RESP.
  task automatic xact(input int d, input logic we,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int lat,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int stall, input string tag);
    int n;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    req_be = be;
    n = 0;
    while (!req_ready_v[d] && n < 10) begin
      step();
      n++;
    end
    chk({tag, ".ready"}, 32'(req_ready_v[d]), 32'd1);
    req_valid_v[d] = 1'b1;
    step();
    req_valid_v[d] = 1'b0;
    n = 1;
    while (!rsp_valid_v[d] && n < 10) begin
      step();
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".rdata"}, rdata_a[d], exp_rd);
    chk({tag, ".err"}, 32'(rsp_err_v[d]), 32'(exp_err));
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, ".hold_v"}, 32'(rsp_valid_v[d]), 32'd1);
      chk({tag, ".hold_d"}, rdata_a[d], exp_rd);
      chk({tag, ".hold_rdy"}, 32'(req_ready_v[d]), 32'd0);
    end
    rsp_ready_v[d] = 1'b1;
    step();
    rsp_ready_v[d] = 1'b0;
    chk({tag, ".done_v"}, 32'(rsp_valid_v[d]), 32'd0);
    chk({tag, ".done_rdy"}, 32'(req_ready_v[d]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    step();
    step();
    chk("rst.ready", 32'(req_ready_v[0]), 32'd0);
    chk("rst.valid", 32'(rsp_valid_v[0]), 32'd0);
    chk("rst.rdata", rdata_a[0], 32'd0);
    chk("rst.err", 32'(rsp_err_v[0]), 32'd0);
    rst = 1'b0;
    step();

    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2,
         32'h0, 1'b0, 0, "st_full");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 2,
         32'hDEADBEEF, 1'b0, 0, "ld_full");
    xact(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 2,
         32'h0, 1'b0, 0, "st_byte");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 2,
         32'hDEADBEAA, 1'b0, 0, "ld_byte");
    xact(0, 1'b0, 32'h12, 32'h0, 4'h0, 2,
         32'h0, 1'b1, 0, "ld_misal");
    xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, 2,
         32'h0, 1'b1, 0, "ld_oor");
    xact(0, 1'b1, 32'h12, 32'h11223344, 4'hF, 2,
         32'h0, 1'b1, 0, "st_misal");
    xact(0, 1'b1, 32'h10, 32'h55667788, 4'h0, 2,
         32'h0, 1'b0, 0, "st_be0");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 2,
         32'hDEADBEAA, 1'b0, 5, "ld_stall");

    // Store accepted, then reset while its response is pending.
    req_we = 1'b1;
    req_addr = 32'h20;
    req_wdata = 32'h12345678;
    req_be = 4'hF;
    req_valid_v[0] = 1'b1;
    step();
    req_valid_v[0] = 1'b0;
    chk("rstw.in_wait", 32'(rsp_valid_v[0]), 32'd0);
    rst = 1'b1;
    #2;
    chk("rstw.ready", 32'(req_ready_v[0]), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | rsp_valid_v[0];
    end
    chk("rstw.no_valid", 32'(seen), 32'd0);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 2,
         32'h12345678, 1'b0, 0, "ld_after_rst");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 2,
         32'hDEADBEAA, 1'b0, 0, "ld_keep");

    xact(1, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, 1,
         32'h0, 1'b0, 0, "l1_st");
    xact(1, 1'b0, 32'h4, 32'h0, 4'h0, 1,
         32'hCAFEF00D, 1'b0, 0, "l1_ld");
    xact(2, 1'b1, 32'h8, 32'h0BADC0DE, 4'hC, 4,
         32'h0, 1'b0, 0, "l4_st");
    xact(2, 1'b1, 32'h8, 32'h00001234, 4'h3, 4,
         32'h0, 1'b0, 0, "l4_st2");
    xact(2, 1'b0, 32'h8, 32'h0, 4'h0, 4,
         32'h0BAD1234, 1'b0, 0, "l4_ld");
    xact(2, 1'b0, 32'h40, 32'h0, 4'h0, 4,
         32'h0, 1'b1, 0, "l4_oor");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
